decode_pipe: RTL and testbench
==============================

DECODE_PIPE -- requirements
Module: decode_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning register/data width.
REQ-002 SHALL have parameter NREG, default 32, meaning architectural register count (power of two); index width AW = log2(NREG).
REQ-003 SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  instruction offered.
REQ-006 SHALL have port in_instr  input  32  RV32 instruction word.
REQ-007 SHALL have port in_ready  output  1  stage accepts in_instr this cycle.
REQ-008 SHALL have port flush  input  1  discard the held instruction and all pending marks.
REQ-009 SHALL have port wb_en  input  1  writeback strobe.
REQ-010 SHALL have port wb_rd  input  AW  writeback register index.
REQ-011 SHALL have port wb_data  input  XLEN  writeback data.
REQ-012 SHALL have port out_valid  output  1  held instruction valid.
REQ-013 SHALL have port out_ready  input  1  downstream accepts.
REQ-014 SHALL have port out_instr  output  32  held instruction.
REQ-015 SHALL have ports out_rs1 and out_rs2  output  XLEN  each  source operand data.
REQ-016 SHALL have port out_rd  output  AW  destination index.
REQ-017 SHALL have port out_rd_we  output  1  destination write intent.
REQ-018 SHALL have port regfile_for_simulator  output  XLEN*NREG  flattened register image; register i at bits [i*XLEN +: XLEN].

Function
REQ-019 SHALL extract fields as follows: rs1 = instr[19:15], rs2 = instr[24:20], rd = instr[11:7], truncated to AW bits.
REQ-020 SHALL set rd_we = 1 unless opcode instr[6:0] is 0100011 (store) or 1100011 (branch), and SHALL force rd_we = 0 when rd = 0.
REQ-021 SHALL hold register 0 at zero permanently; writes to it are ignored.
REQ-022 SHALL keep a pending bit per register; a set bit means an issued writer of that register has not yet written back.
REQ-023 SHALL treat a source as hazardous when its pending bit is set and no same-cycle writeback clears it.
REQ-024 SHALL assert in_ready = (!out_valid || out_ready) && !hazard(rs1) && !hazard(rs2) && !flush.
REQ-025 SHALL, on in_valid && in_ready, capture on the next edge: the instruction, rs1/rs2 data read from the regfile, rd and rd_we; out_valid rises one cycle after acceptance (latency 1).
REQ-026 SHALL, on the same acceptance with rd_we = 1, set pending[rd].
REQ-027 SHALL clear pending[wb_rd] on wb_en; when the same register is set and cleared in one cycle, set wins.
REQ-028 SHALL write wb_data to wb_rd on wb_en at the edge.
REQ-029 SHALL keep out_* stable while out_valid && !out_ready.
REQ-030 SHALL drop out_valid on out_valid && out_ready with no new acceptance.
REQ-031 SHALL, on flush, clear out_valid and all pending bits at the next edge, accept nothing that cycle, and still perform that cycle's writeback.

Reset
REQ-032 SHALL, while rst = 0, clear every register, all pending bits and out_valid, and drive out_instr, out_rs1, out_rs2, out_rd and out_rd_we to 0.
REQ-033 SHALL discard the held instruction when reset is asserted mid-operation; the first acceptance is possible in the cycle after rst rises.

Configuration
REQ-034 SHALL provide macro DECODE_PIPE_BYPASS_EN; when defined, a source equal to wb_rd (non-zero) with wb_en set SHALL read wb_data in the same cycle and be non-hazardous.
REQ-035 SHALL, without DECODE_PIPE_BYPASS_EN, return the old register value and treat a pending source as hazardous until the cycle after writeback.

Structure
REQ-036 SHALL place the opcode constants (OP_STORE, OP_BRANCH) and the field-position constants in package decode_pkg.
REQ-037 SHALL instantiate sub-module regfile_mp (NREG x XLEN, two asynchronous read ports, one synchronous write port, x0 hard zero, simulator image output).

Verification
REQ-038 SHALL test: after reset, write x5 = 0xDEADBEEF, then issue add x6, x5, x0 -> out_rs1 = 0xDEADBEEF, out_rd = 6, out_rd_we = 1, out_valid one cycle after acceptance.
REQ-039 SHALL test: issue a writer of x7, then a reader of x7 -> in_ready = 0 until wb_en with wb_rd = 7; with bypass the reader is accepted in the writeback cycle, without bypass one cycle later.
REQ-040 SHALL test: out_ready = 0 for 3 cycles with out_valid = 1 -> out_* unchanged and in_ready = 0 throughout.
REQ-041 SHALL test: wb_en with wb_rd = 0 and wb_data = 0x1234 -> x0 stays 0 and regfile_for_simulator[31:0] = 0.
REQ-042 SHALL test: flush with out_valid = 1 and pending bits for x3 and x9 set -> next cycle out_valid = 0 and a reader of x3 is accepted immediately.
REQ-043 SHALL test: rst driven low mid-stall -> all outputs return to 0 asynchronously.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared RV32 decode constants: opcode values and instruction field positions.
package decode_pkg;

    localparam int INSTR_W = 32;
    localparam int OPC_LSB = 0;
    localparam int OPC_W   = 7;
    localparam int RD_LSB  = 7;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;

    typedef logic [OPC_W-1:0] opcode_t;

    localparam opcode_t OP_STORE  = 7'b0100011;
    localparam opcode_t OP_BRANCH = 7'b1100011;

    // Stores and branches are the only RV32 base opcodes without a destination.
    function automatic logic opcode_writes_rd(input opcode_t opc);
        return !((opc == OP_STORE) || (opc == OP_BRANCH));
    endfunction

endpackage

// File: rtl/decode_pipe_if.sv
// Instruction-in / decoded-out handshake bundle for decode_pipe.
interface decode_pipe_if
    import decode_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32
);
    localparam int AW = $clog2(NREG);

    logic               in_valid;
    logic [INSTR_W-1:0] in_instr;
    logic               in_ready;

    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [XLEN-1:0]    out_rs1;
    logic [XLEN-1:0]    out_rs2;
    logic [AW-1:0]      out_rd;
    logic               out_rd_we;

    modport master (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, out_instr, out_rs1, out_rs2, out_rd, out_rd_we
    );

    modport slave (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, out_instr, out_rs1, out_rs2, out_rd, out_rd_we
    );

endinterface

// File: rtl/decode_pipe_regfile_mp.sv
// Register file: NREG x XLEN, two asynchronous read ports, one synchronous
// write port, x0 hard-wired to zero, flattened image for simulation visibility.
module regfile_mp #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(NREG)-1:0]  waddr,
    input  logic [XLEN-1:0]          wdata,
    input  logic [$clog2(NREG)-1:0]  raddr1,
    output logic [XLEN-1:0]          rdata1,
    input  logic [$clog2(NREG)-1:0]  raddr2,
    output logic [XLEN-1:0]          rdata2,
    output logic [XLEN*NREG-1:0]     image
);
    localparam int AW = $clog2(NREG);

    logic [NREG-1:0][XLEN-1:0] regs_reg;
    logic [NREG-1:0]           wsel;

    // Entry 0 never gets a write select, so it stays at its reset value of zero.
    assign wsel[0] = 1'b0;
    for (genvar gi = 1; gi < NREG; gi++) begin : g_wsel
        assign wsel[gi] = we && (waddr == AW'(gi));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regs_reg <= '0;
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (wsel[i]) begin
                    regs_reg[i] <= wdata;
                end
            end
        end
    end

    assign rdata1 = regs_reg[raddr1];
    assign rdata2 = regs_reg[raddr2];
    assign image  = regs_reg;

endmodule

// File: rtl/decode_pipe.sv
// Decode stage: field extraction, operand read, scoreboard interlock, 1-deep output.
// Optional same-cycle writeback bypass enabled by macro DECODE_PIPE_BYPASS_EN.
module decode_pipe
    import decode_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    decode_pipe_if.slave            bus,
    input  logic                    flush,
    input  logic                    wb_en,
    input  logic [$clog2(NREG)-1:0] wb_rd,
    input  logic [XLEN-1:0]         wb_data,
    output logic [XLEN*NREG-1:0]    regfile_for_simulator
);
    localparam int AW = $clog2(NREG);

    logic [AW-1:0]      rs1_idx, rs2_idx, rd_idx;
    logic               rd_we_dec;
    logic [XLEN-1:0]    rf_rd1, rf_rd2, src1, src2;
    logic               haz1, haz2, accept;
    logic [NREG-1:0]    pend_reg, pend_next;

    logic               out_valid_reg;
    logic [INSTR_W-1:0] out_instr_reg;
    logic [XLEN-1:0]    out_rs1_reg, out_rs2_reg;
    logic [AW-1:0]      out_rd_reg;
    logic               out_rd_we_reg;

    assign rs1_idx   = bus.in_instr[RS1_LSB +: AW];
    assign rs2_idx   = bus.in_instr[RS2_LSB +: AW];
    assign rd_idx    = bus.in_instr[RD_LSB +: AW];
    assign rd_we_dec = opcode_writes_rd(bus.in_instr[OPC_LSB +: OPC_W]) && (rd_idx != '0);

    regfile_mp #(.XLEN(XLEN), .NREG(NREG)) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .we     (wb_en),
        .waddr  (wb_rd),
        .wdata  (wb_data),
        .raddr1 (rs1_idx),
        .rdata1 (rf_rd1),
        .raddr2 (rs2_idx),
        .rdata2 (rf_rd2),
        .image  (regfile_for_simulator)
    );

`ifdef DECODE_PIPE_BYPASS_EN
    logic byp1, byp2;
    assign byp1 = wb_en && (wb_rd == rs1_idx) && (rs1_idx != '0);
    assign byp2 = wb_en && (wb_rd == rs2_idx) && (rs2_idx != '0);
    assign src1 = byp1 ? wb_data : rf_rd1;
    assign src2 = byp2 ? wb_data : rf_rd2;
    assign haz1 = pend_reg[rs1_idx] && !byp1;
    assign haz2 = pend_reg[rs2_idx] && !byp2;
`else
    // Without forwarding a pending source stays blocked until the write has landed.
    assign src1 = rf_rd1;
    assign src2 = rf_rd2;
    assign haz1 = pend_reg[rs1_idx];
    assign haz2 = pend_reg[rs2_idx];
`endif

    assign bus.in_ready = (!out_valid_reg || bus.out_ready) && !haz1 && !haz2 && !flush;
    assign accept       = bus.in_valid && bus.in_ready;

    // A new issue to a register outranks a same-cycle writeback clearing it.
    assign pend_next[0] = 1'b0;
    for (genvar gi = 1; gi < NREG; gi++) begin : g_pend
        assign pend_next[gi] = !flush &&
            ((accept && rd_we_dec && (rd_idx == AW'(gi))) ||
             (pend_reg[gi] && !(wb_en && (wb_rd == AW'(gi)))));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_reg      <= '0;
            out_valid_reg <= 1'b0;
            out_instr_reg <= '0;
            out_rs1_reg   <= '0;
            out_rs2_reg   <= '0;
            out_rd_reg    <= '0;
            out_rd_we_reg <= 1'b0;
        end else begin
            pend_reg <= pend_next;
            if (flush) begin
                out_valid_reg <= 1'b0;
            end else if (accept) begin
                out_valid_reg <= 1'b1;
                out_instr_reg <= bus.in_instr;
                out_rs1_reg   <= src1;
                out_rs2_reg   <= src2;
                out_rd_reg    <= rd_idx;
                out_rd_we_reg <= rd_we_dec;
            end else if (bus.out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign bus.out_valid = out_valid_reg;
    assign bus.out_instr = out_instr_reg;
    assign bus.out_rs1   = out_rs1_reg;
    assign bus.out_rs2   = out_rs2_reg;
    assign bus.out_rd    = out_rd_reg;
    assign bus.out_rd_we = out_rd_we_reg;

endmodule

// File: tb/tb_decode_pipe.sv
// Self-checking bench for decode_pipe: directed scenarios plus a cycle-level reference model.
module tb_decode_pipe;
    localparam int XLEN = 32;
    localparam int NREG = 32;
`ifdef DECODE_PIPE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              flush = 1'b0;
    logic              wb_en = 1'b0;
    logic [4:0]        wb_rd = '0;
    logic [31:0]       wb_data = '0;
    logic [XLEN*NREG-1:0] img;

    int total = 0;
    int bad   = 0;

    decode_pipe_if #(.XLEN(XLEN), .NREG(NREG)) bus ();

    decode_pipe #(.XLEN(XLEN), .NREG(NREG)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .bus                   (bus),
        .flush                 (flush),
        .wb_en                 (wb_en),
        .wb_rd                 (wb_rd),
        .wb_data               (wb_data),
        .regfile_for_simulator (img)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    function automatic logic [31:0] r_add(input int rd, input int rs1, input int rs2);
        logic [4:0] d, a, b;
        d = rd[4:0];
        a = rs1[4:0];
        b = rs2[4:0];
        return {7'b0000000, b, a, 3'b000, d, 7'b0110011};
    endfunction

    // ---------------- reference model ----------------
    logic [31:0] m_regs [32];
    logic [31:0] m_pend;
    logic        m_valid;
    logic [31:0] m_instr, m_rs1, m_rs2;
    logic [4:0]  m_rd;
    logic        m_we;

    function automatic logic m_fwd(input logic [4:0] s);
        return BYP && wb_en && (wb_rd == s) && (s != 5'd0);
    endfunction

    function automatic logic m_blocked(input logic [4:0] s);
        return m_pend[s] && !m_fwd(s);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] s);
        if (s == 5'd0) return 32'h0;
        if (m_fwd(s)) return wb_data;
        return m_regs[s];
    endfunction

    function automatic logic m_dest(input logic [31:0] ins);
        return (ins[6:0] != 7'b0100011) && (ins[6:0] != 7'b1100011) && (ins[11:7] != 5'd0);
    endfunction

    function automatic logic m_ready();
        return (!m_valid || bus.out_ready) && !flush &&
               !m_blocked(bus.in_instr[19:15]) && !m_blocked(bus.in_instr[24:20]);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] <= 32'h0;
            m_pend  <= '0;
            m_valid <= 1'b0;
            m_instr <= '0;
            m_rs1   <= '0;
            m_rs2   <= '0;
            m_rd    <= '0;
            m_we    <= 1'b0;
        end else begin
            if (flush) begin
                m_valid <= 1'b0;
                m_pend  <= '0;
            end else begin
                if (bus.in_valid && m_ready()) begin
                    m_valid <= 1'b1;
                    m_instr <= bus.in_instr;
                    m_rs1   <= m_read(bus.in_instr[19:15]);
                    m_rs2   <= m_read(bus.in_instr[24:20]);
                    m_rd    <= bus.in_instr[11:7];
                    m_we    <= m_dest(bus.in_instr);
                end else if (bus.out_ready) begin
                    m_valid <= 1'b0;
                end
                if (wb_en) m_pend[wb_rd] <= 1'b0;
                if (bus.in_valid && m_ready() && m_dest(bus.in_instr))
                    m_pend[bus.in_instr[11:7]] <= 1'b1;
            end
            if (wb_en && wb_rd != 5'd0) m_regs[wb_rd] <= wb_data;
        end
    end

    // Every out-of-reset cycle: handshake, held payload and register image.
    always @(negedge clk) begin
        if (rst) begin
            chk("cmp_in_ready", bus.in_ready, m_ready());
            chk("cmp_out_valid", bus.out_valid, m_valid);
            if (m_valid) begin
                chk("cmp_out_instr", bus.out_instr, m_instr);
                chk("cmp_out_rs1", bus.out_rs1, m_rs1);
                chk("cmp_out_rs2", bus.out_rs2, m_rs2);
                chk("cmp_out_rd", bus.out_rd, m_rd);
                chk("cmp_out_rd_we", bus.out_rd_we, m_we);
            end
            for (int i = 0; i < 32; i++) chk("cmp_regimg", img[i*32 +: 32], m_regs[i]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_instr", bus.out_instr, 0);
        chk("rst_out_rs1", bus.out_rs1, 0);
        chk("rst_out_rd_we", bus.out_rd_we, 0);
        #3 rst = 1'b1;
        tick();

        // x5 = DEADBEEF, then add x6, x5, x0
        wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
        tick();
        wb_en = 1'b0;
        bus.in_valid = 1'b1; bus.in_instr = r_add(6, 5, 0);
        #1;
        chk("a_ready", bus.in_ready, 1);
        chk("a_valid_before", bus.out_valid, 0);
        tick();
        bus.in_valid = 1'b0;
        #1;
        chk("a_valid", bus.out_valid, 1);
        chk("a_rs1", bus.out_rs1, 32'hDEADBEEF);
        chk("a_rd", bus.out_rd, 6);
        chk("a_rd_we", bus.out_rd_we, 1);
        chk("a_model_rs1", m_rs1, 32'hDEADBEEF);
        tick();
        #1 chk("a_drop", bus.out_valid, 0);

        // writer of x7 followed by reader of x7
        bus.in_valid = 1'b1; bus.in_instr = r_add(7, 0, 0);
        tick();
        bus.in_instr = r_add(8, 7, 0);
        #1 chk("b_haz0", bus.in_ready, 0);
        tick();
        #1 chk("b_haz1", bus.in_ready, 0);
        wb_en = 1'b1; wb_rd = 5'd7; wb_data = 32'h77;
`ifdef DECODE_PIPE_BYPASS_EN
        #1 chk("b_wb_cycle_ready", bus.in_ready, 1);
        tick();
        wb_en = 1'b0; bus.in_valid = 1'b0;
`else
        #1 chk("b_wb_cycle_ready", bus.in_ready, 0);
        tick();
        wb_en = 1'b0;
        #1 chk("b_after_wb_ready", bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
`endif
        #1;
        chk("b_valid", bus.out_valid, 1);
        chk("b_rs1", bus.out_rs1, 32'h77);
        chk("b_rd", bus.out_rd, 8);
        tick();

        // issue to x7 in the same cycle x7 is written back: pending must stay set
        bus.in_valid = 1'b1; bus.in_instr = r_add(7, 0, 0);
        wb_en = 1'b1; wb_rd = 5'd7; wb_data = 32'h99;
        #1 chk("b2_ready", bus.in_ready, 1);
        tick();
        wb_en = 1'b0; bus.in_instr = r_add(9, 7, 0);
        #1 chk("b2_set_wins", bus.in_ready, 0);
        bus.in_valid = 1'b0;
        wb_en = 1'b1; wb_rd = 5'd7; wb_data = 32'hAA;
        tick();
        wb_en = 1'b0;
        tick();

        // downstream stall for 3 cycles
        bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_instr = r_add(10, 0, 0);
        tick();
        bus.in_instr = r_add(11, 0, 0);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("c_valid", bus.out_valid, 1);
            chk("c_instr", bus.out_instr, r_add(10, 0, 0));
            chk("c_rd", bus.out_rd, 10);
            chk("c_ready", bus.in_ready, 0);
            tick();
        end
        bus.out_ready = 1'b1;
        #1 chk("c_release", bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
        #1 chk("c_next", bus.out_instr, r_add(11, 0, 0));
        tick();

        // writeback to x0 is dropped, and x0 is never forwarded
        wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'h1234;
        bus.in_valid = 1'b1; bus.in_instr = r_add(12, 0, 0);
        tick();
        wb_en = 1'b0; bus.in_valid = 1'b0;
        #1;
        chk("d_x0_img", img[31:0], 0);
        chk("d_x0_read", bus.out_rs1, 0);
        tick();

        // flush with pending x3 and x9 and a held instruction
        bus.in_valid = 1'b1; bus.in_instr = r_add(3, 0, 0);
        tick();
        bus.in_instr = r_add(9, 0, 0);
        tick();
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.in_instr = r_add(13, 3, 0);
        #1;
        chk("e_held", bus.out_valid, 1);
        chk("e_haz", bus.in_ready, 0);
        flush = 1'b1;
        #1 chk("e_flush_ready", bus.in_ready, 0);
        tick();
        flush = 1'b0; bus.in_valid = 1'b1;
        #1;
        chk("e_cleared", bus.out_valid, 0);
        chk("e_accept", bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
        #1;
        chk("e_valid", bus.out_valid, 1);
        chk("e_instr", bus.out_instr, r_add(13, 3, 0));
        tick();

        // asynchronous reset in the middle of a stall
        #2 rst = 1'b0;
        #1;
        chk("f_out_valid", bus.out_valid, 0);
        chk("f_out_instr", bus.out_instr, 0);
        chk("f_out_rs1", bus.out_rs1, 0);
        chk("f_out_rs2", bus.out_rs2, 0);
        chk("f_out_rd", bus.out_rd, 0);
        chk("f_out_rd_we", bus.out_rd_we, 0);
        chk("f_x5_img", img[5*32 +: 32], 0);
        bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.in_instr = r_add(14, 0, 0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        #1;
        chk("f_first_valid", bus.out_valid, 1);
        chk("f_first_rd", bus.out_rd, 14);
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
